// File: rtl/vecmat_acc_32_pkg.sv
// Shared widths and accumulate-stage types for the 32-lane dot-product reduction.
// Lanes and results are signed fixed point with FRAC_BITS fractional bits.
package vecmat_acc_32_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 12;
  localparam int LANES      = 32;
  localparam int ACC_W      = 24;
  localparam int MAX_BEATS  = 8;
  localparam int CNT_W      = 4;

  typedef struct packed {
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic                    done;
  } acc_st_t;

  // Beat count for the group: restarts at 1, saturates at all-ones.
  function automatic logic [CNT_W-1:0] cnt_next(input logic first, input logic [CNT_W-1:0] cnt);
    if (first) return CNT_W'(1);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction
endpackage

// File: rtl/vecmat_acc_32_add_tree_stage.sv
// One registered adder-tree level: N signed W-bit inputs -> N/2 sums of W+1 bits.
// valid/last are registered alongside so the data and its qualifiers stay aligned.
module add_tree_stage #(
  parameter int N = 2,
  parameter int W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid,
  input  logic                   last,
  input  logic [N*W-1:0]         data,
  output logic                   sum_valid,
  output logic                   sum_last,
  output logic [(N/2)*(W+1)-1:0] sum
);
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_valid <= 1'b0;
      sum_last  <= 1'b0;
    end else begin
      sum_valid <= valid;
      sum_last  <= valid & last;
    end
  end

  // Sign-extend before adding so no level ever truncates.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N/2; i++) begin
      sum[i*(W+1) +: W+1] <= {data[2*i*W+W-1], data[2*i*W +: W]}
                           + {data[(2*i+1)*W+W-1], data[(2*i+1)*W +: W]};
    end
  end
endmodule

// File: rtl/vecmat_acc_32.sv
// 32-lane adder tree + per-group accumulator producing one 16-bit dot-product element.
// Define VECMAT_ACC_SAT_EN to clamp out-of-range results instead of wrapping.
module vecmat_acc_32
  import vecmat_acc_32_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic                        in_last,
  input  logic [LANES*DATA_WIDTH-1:0] lanes,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       out_sum,
  output logic                        out_ovf,
  output logic [CNT_W-1:0]            out_count
);
  localparam int LVLS  = $clog2(LANES);
  localparam int SUM_W = DATA_WIDTH + LVLS;
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;

  for (genvar k = 0; k < LVLS; k++) begin : g_lvl
    localparam int N = LANES >> k;
    localparam int W = DATA_WIDTH + k;
    logic [(N/2)*(W+1)-1:0] sum;
    logic vld, last;
    if (k == 0) begin : g_first
      add_tree_stage #(.N(N), .W(W)) u_stage (
        .clk, .reset, .valid(in_valid), .last(in_last), .data(lanes),
        .sum_valid(vld), .sum_last(last), .sum(sum)
      );
    end else begin : g_next
      add_tree_stage #(.N(N), .W(W)) u_stage (
        .clk, .reset, .valid(g_lvl[k-1].vld), .last(g_lvl[k-1].last), .data(g_lvl[k-1].sum),
        .sum_valid(vld), .sum_last(last), .sum(sum)
      );
    end
  end

  logic [SUM_W-1:0] t_sum;
  logic             t_vld, t_last;
  logic [ACC_W-1:0] acc_in;
  assign t_sum  = g_lvl[LVLS-1].sum;
  assign t_vld  = g_lvl[LVLS-1].vld;
  assign t_last = g_lvl[LVLS-1].last;
  assign acc_in = {{(ACC_W-SUM_W){t_sum[SUM_W-1]}}, t_sum};

  acc_st_t st;
  logic    first;

  always_ff @(posedge clk) begin
    if (!reset) begin
      st    <= '0;
      first <= 1'b1;
    end else begin
      st.done <= t_vld & t_last;
      if (t_vld) begin
        st.acc <= (first ? '0 : st.acc) + acc_in;
        st.cnt <= cnt_next(first, st.cnt);
        first  <= t_last;
      end
    end
  end

  logic                  hi, lo, ovf;
  logic [DATA_WIDTH-1:0] res;
  assign hi  = $signed(st.acc) > ACC_MAX;
  assign lo  = $signed(st.acc) < ACC_MIN;
  assign ovf = hi | lo | (st.cnt > CNT_W'(MAX_BEATS));

  always_comb begin
    res = st.acc[DATA_WIDTH-1:0];
`ifdef VECMAT_ACC_SAT_EN
    if (hi)      res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (lo) res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_count <= '0;
    end else begin
      out_valid <= st.done;
      if (st.done) begin
        out_sum   <= res;
        out_ovf   <= ovf;
        out_count <= st.cnt;
      end
    end
  end
endmodule

// File: tb/tb_vecmat_acc_32.sv
// Directed bench for vecmat_acc_32: single-beat vector table plus multi-beat group sequences.
module tb_vecmat_acc_32;
  import vecmat_acc_32_pkg::*;
  localparam int DW = DATA_WIDTH;

  logic                clk = 1'b0;
  logic                reset, in_valid, in_last;
  logic [LANES*DW-1:0] lanes;
  logic                out_valid, out_ovf;
  logic [DW-1:0]       out_sum;
  logic [CNT_W-1:0]    out_count;

  vecmat_acc_32 dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last), .lanes(lanes),
    .out_valid(out_valid), .out_sum(out_sum), .out_ovf(out_ovf), .out_count(out_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] sum;
    logic        ovf;
    logic [3:0]  count;
    int          at;
  } pulse_t;
  pulse_t q[$];
  always @(negedge clk) if (out_valid === 1'b1) q.push_back('{out_sum, out_ovf, out_count, cyc});

  int total = 0, bad = 0;
  int last_drive = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [LANES*DW-1:0] fill(input int mode, input logic [15:0] v);
    logic [LANES*DW-1:0] d;
    for (int i = 0; i < LANES; i++)
      d[i*DW +: DW] = (mode == 0) ? v : (mode == 1) ? 16'(i) : 16'(-i);
    return d;
  endfunction

  function automatic logic [15:0] pick(input logic [15:0] wrap, input logic [15:0] sat);
`ifdef VECMAT_ACC_SAT_EN
    return sat;
`else
    return wrap;
`endif
  endfunction

  task automatic beat(input logic v, input logic l, input logic [LANES*DW-1:0] d);
    @(negedge clk);
    in_valid = v; in_last = l; lanes = d;
    if (v && l) last_drive = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
    end
  endtask

  task automatic expect_one(input string n, input logic [15:0] s, input logic o, input int c);
    idle(14);
    chk({n, ".pulses"}, q.size(), 1);
    if (q.size() >= 1) begin
      chk({n, ".sum"}, int'(q[0].sum), int'(s));
      chk({n, ".ovf"}, int'(q[0].ovf), int'(o));
      chk({n, ".count"}, int'(q[0].count), c);
      chk({n, ".latency"}, q[0].at - last_drive, 7);
    end
    q.delete();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    int          mode;
    logic [15:0] val;
    logic [15:0] exp_wrap;
    logic [15:0] exp_sat;
    logic        exp_ovf;
  } vec_t;
  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 16'h0040, 16'h0800, 16'h0800, 1'b0};
    vecs[1] = '{0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[2] = '{0, 16'hFFFF, 16'hFFE0, 16'hFFE0, 1'b0};
    vecs[3] = '{0, 16'h7FFF, 16'hFFE0, 16'h7FFF, 1'b1};
    vecs[4] = '{0, 16'h8000, 16'h0000, 16'h8000, 1'b1};
    vecs[5] = '{0, 16'h0400, 16'h8000, 16'h7FFF, 1'b1};
    vecs[6] = '{0, 16'hFC00, 16'h8000, 16'h8000, 1'b0};
    vecs[7] = '{0, 16'h03FF, 16'h7FE0, 16'h7FE0, 1'b0};
    vecs[8] = '{1, 16'h0000, 16'h01F0, 16'h01F0, 1'b0};
    vecs[9] = '{2, 16'h0000, 16'hFE10, 16'hFE10, 1'b0};

    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; lanes = '0;
    repeat (3) @(negedge clk);
    chk("reset.valid", int'(out_valid), 0);
    chk("reset.sum", int'(out_sum), 0);
    chk("reset.ovf", int'(out_ovf), 0);
    chk("reset.count", int'(out_count), 0);
    reset = 1'b1;
    idle(2);
    q.delete();

    foreach (vecs[i]) begin
      beat(1'b1, 1'b1, fill(vecs[i].mode, vecs[i].val));
      expect_one($sformatf("vec%0d", i), pick(vecs[i].exp_wrap, vecs[i].exp_sat), vecs[i].exp_ovf, 1);
    end

    // 4-beat negative group
    for (int b = 0; b < 4; b++) beat(1'b1, b == 3, fill(0, 16'hFFFF));
    expect_one("t2", 16'hFF80, 1'b0, 4);

    // group with a bubble, then a back-to-back single-beat group
    beat(1'b1, 1'b0, fill(0, 16'h0010));
    beat(1'b1, 1'b0, fill(0, 16'h0010));
    beat(1'b0, 1'b0, fill(0, 16'h0010));
    beat(1'b1, 1'b1, fill(0, 16'h0010));
    beat(1'b1, 1'b1, fill(0, 16'h0020));
    idle(14);
    chk("t4.pulses", q.size(), 2);
    if (q.size() == 2) begin
      chk("t4.a.sum", int'(q[0].sum), 'h0600);
      chk("t4.a.count", int'(q[0].count), 3);
      chk("t4.b.sum", int'(q[1].sum), 'h0400);
      chk("t4.b.count", int'(q[1].count), 1);
      chk("t4.gap", q[1].at - q[0].at, 1);
      chk("t4.b.latency", q[1].at - last_drive, 7);
    end
    q.delete();

    // reset after partial group has reached the accumulator
    beat(1'b1, 1'b0, fill(0, 16'h0001));
    beat(1'b1, 1'b0, fill(0, 16'h0001));
    idle(7);
    pulse_reset();
    chk("t5.rst.sum", int'(out_sum), 0);
    chk("t5.rst.count", int'(out_count), 0);
    // reset while a closing beat is still inside the tree
    beat(1'b1, 1'b1, fill(0, 16'h0001));
    idle(2);
    pulse_reset();
    idle(12);
    chk("t5.aborted.pulses", q.size(), 0);
    q.delete();
    beat(1'b1, 1'b1, fill(0, 16'h0001));
    expect_one("t5", 16'h0020, 1'b0, 1);

    // exactly MAX_BEATS: no overflow
    for (int b = 0; b < 8; b++) beat(1'b1, b == 7, fill(0, 16'h0001));
    expect_one("t6.max", 16'h0100, 1'b0, 8);

    // 9 beats with a stray unqualified in_last in the middle
    for (int b = 0; b < 9; b++) begin
      if (b == 4) beat(1'b0, 1'b1, fill(0, 16'h0001));
      beat(1'b1, b == 8, fill(0, 16'h0001));
    end
    expect_one("t6.nine", 16'h0120, 1'b1, 9);

    // count saturation
    for (int b = 0; b < 17; b++) beat(1'b1, b == 16, fill(0, 16'h0001));
    expect_one("t6.sat", 16'h0220, 1'b1, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
